// File: rtl/mandel_pixel_scheduler_if.sv
// mandel_pixel_scheduler_if: control, engine dispatch/result and VGA plot bundle
// master (scheduler): in start, eng_valid, eng_iter; out done, eng_start, eng_x, eng_y, eng_ack, vga_*
// slave (environment): the mirror image of master
interface mandel_pixel_scheduler_if #(
  parameter int NUM_ENG = 4,
  parameter int ITER_W  = 8
);
  logic                      start;
  logic                      done;
  logic [NUM_ENG-1:0]        eng_start;
  logic [7:0]                eng_x;
  logic [6:0]                eng_y;
  logic [NUM_ENG-1:0]        eng_valid;
  logic [NUM_ENG*ITER_W-1:0] eng_iter;
  logic [NUM_ENG-1:0]        eng_ack;
  logic [7:0]                vga_x;
  logic [6:0]                vga_y;
  logic [2:0]                vga_colour;
  logic                      vga_plot;
  modport master (
    input  start, eng_valid, eng_iter,
    output done, eng_start, eng_x, eng_y, eng_ack, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    output start, eng_valid, eng_iter,
    input  done, eng_start, eng_x, eng_y, eng_ack, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: walks the raster, dispatches pixels to free engines, round-robins results to the VGA plot port
// CLOCK_50 : system clock, rising edge
// reset    : asynchronous active-high reset
// bus      : master side of mandel_pixel_scheduler_if (start/done, engine dispatch/ack, VGA plot)
module mandel_pixel_scheduler #(
  parameter int NUM_ENG  = 4,
  parameter int XMAX     = 160,
  parameter int YMAX     = 120,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input logic                      CLOCK_50,
  input logic                      reset,
  mandel_pixel_scheduler_if.master bus
);
  localparam int PW = NUM_ENG > 1 ? $clog2(NUM_ENG) : 1;
  localparam logic [7:0] XL = 8'(XMAX - 1);
  localparam logic [6:0] YL = 7'(YMAX - 1);
  localparam logic [31:0] MI = MAX_ITER;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [NUM_ENG-1:0] r_occ, w_start, w_ack;
  logic [PW-1:0] r_dptr, r_gptr, w_dk, w_gk;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [7:0] r_tag_x [NUM_ENG];
  logic [6:0] r_tag_y [NUM_ENG];
  logic [ITER_W-1:0] w_iter;
  logic w_disp, w_grant, w_go, w_last;
  // Scanning offsets from high to low leaves the nearest candidate at or after each pointer.
  always_comb begin
    w_dk = r_dptr;
    w_gk = r_gptr;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (!r_occ[PW'((int'(r_dptr) + i) % NUM_ENG)]) w_dk = PW'((int'(r_dptr) + i) % NUM_ENG);
      if (r_occ[PW'((int'(r_gptr) + i) % NUM_ENG)] && bus.eng_valid[PW'((int'(r_gptr) + i) % NUM_ENG)])
        w_gk = PW'((int'(r_gptr) + i) % NUM_ENG);
    end
  end
  assign w_go    = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_disp  = r_state == S_RUN && !(&r_occ);
  assign w_grant = (r_state == S_RUN || r_state == S_DRAIN) && |(r_occ & bus.eng_valid);
  assign w_last  = w_disp && r_x == XL && r_y == YL;
  assign w_start = w_disp ? NUM_ENG'(1) << w_dk : '0;
  assign w_ack   = w_grant ? NUM_ENG'(1) << w_gk : '0;
  assign w_iter  = bus.eng_iter[int'(w_gk)*ITER_W +: ITER_W];
  assign bus.eng_start = w_start;
  assign bus.eng_ack   = w_ack;
  assign bus.eng_x     = r_x;
  assign bus.eng_y     = r_y;
  assign bus.done      = r_state == S_DONE;
  always_comb
    w_next = w_go ? S_RUN :
             w_last ? S_DRAIN :
             (r_state == S_DRAIN && r_occ == '0) ? S_DONE : r_state;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      r_occ          <= '0;
      r_dptr         <= '0;
      r_gptr         <= '0;
      r_x            <= '0;
      r_y            <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else if (w_go) begin
      r_occ        <= '0;
      r_dptr       <= '0;
      r_gptr       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      bus.vga_plot <= 1'b0;
    end else begin
      r_occ        <= (r_occ | w_start) & ~w_ack;
      bus.vga_plot <= w_grant;
      if (w_disp) begin
        r_dptr <= w_dk == PW'(NUM_ENG - 1) ? '0 : w_dk + 1'b1;
        r_x    <= r_x == XL ? 8'd0 : r_x + 8'd1;
        r_y    <= r_x == XL ? r_y + 7'd1 : r_y;
      end
      if (w_grant) begin
        r_gptr         <= w_gk == PW'(NUM_ENG - 1) ? '0 : w_gk + 1'b1;
        bus.vga_x      <= r_tag_x[w_gk];
        bus.vga_y      <= r_tag_y[w_gk];
        bus.vga_colour <= 32'(w_iter) >= MI ? 3'd0 : w_iter[2:0];
      end
    end
  always_ff @(posedge CLOCK_50)
    if (w_disp) begin
      r_tag_x[w_dk] <= r_x;
      r_tag_y[w_dk] <= r_y;
    end
endmodule
